// File: rtl/counter_change_capture.sv
// counter_change_capture: samples a watched counter, records every value change
// together with a free-running timestamp, and buffers the events in a FIFO that
// is drained over a valid/ready port.
// Optional feature macro: CCC_DELTA_EN adds a per-event delta output (evt_delta).
module counter_change_capture #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TS_W   = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_en,
    input  logic [DATA_W-1:0]          counter_in,
    input  logic                       clear,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [DATA_W-1:0]          evt_data,
    output logic [TS_W-1:0]            evt_ts,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                drop_count,
    output logic                       overflow
`ifdef CCC_DELTA_EN
    ,
    output logic [DATA_W-1:0]          evt_delta
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] prev;
    logic              primed;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [TS_W-1:0]   mem_ts   [DEPTH];

    logic empty_c;
    logic full_c;
    logic push_req_c;
    logic pop_c;
    logic wr_en_c;
    logic drop_c;

    // FIFO status, change detection and push/pop/drop qualification
    always_comb begin
        empty_c    = (wr_ptr == rd_ptr);
        full_c     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        push_req_c = sample_en && (!primed || (counter_in != prev));
        pop_c      = !empty_c && evt_ready;
        wr_en_c    = !clear && push_req_c && (!full_c || pop_c);
        drop_c     = !clear && push_req_c && full_c && !pop_c;
    end

    // Timestamp runs every cycle and is deliberately untouched by clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    // Pointers, change-detect history and drop statistics; clear outranks push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            prev       <= '0;
            primed     <= 1'b0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            primed     <= 1'b0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (sample_en) begin
                prev   <= counter_in;
                primed <= 1'b1;
            end
            if (drop_c) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

    // Event storage; entries are only visible through the valid-gated head mux
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_data[wr_ptr[AW-1:0]] <= counter_in;
            mem_ts[wr_ptr[AW-1:0]]   <= ts;
        end
    end

`ifdef CCC_DELTA_EN
    logic [DATA_W-1:0] mem_delta [DEPTH];

    // Per-entry delta from the previous sample; zero for the first push after reset/clear
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_delta[wr_ptr[AW-1:0]] <= primed ? (counter_in - prev) : '0;
        end
    end

    // Head delta, forced to zero while the FIFO is empty
    always_comb begin
        evt_delta = empty_c ? '0 : mem_delta[rd_ptr[AW-1:0]];
    end
`endif

    // Head presentation and occupancy, all decoded straight from flops
    always_comb begin
        evt_valid = !empty_c;
        evt_data  = empty_c ? '0 : mem_data[rd_ptr[AW-1:0]];
        evt_ts    = empty_c ? '0 : mem_ts[rd_ptr[AW-1:0]];
        level     = wr_ptr - rd_ptr;
    end

endmodule

// File: tb/tb_counter_change_capture.sv
// Bench for counter_change_capture: reset/latency table, directed corner
// sequences and random traffic against an event-queue reference model.
// Define CCC_DELTA_EN for both files to exercise evt_delta.
module tb_counter_change_capture;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TS_W   = 32;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned LW     = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst_n;
    logic              sample_en;
    logic [DATA_W-1:0] counter_in;
    logic              clear;
    logic              evt_valid;
    logic              evt_ready;
    logic [DATA_W-1:0] evt_data;
    logic [TS_W-1:0]   evt_ts;
    logic [LW-1:0]     level;
    logic [15:0]       drop_count;
    logic              overflow;
`ifdef CCC_DELTA_EN
    logic [DATA_W-1:0] evt_delta;
`endif

    counter_change_capture #(
        .DATA_W (DATA_W),
        .TS_W   (TS_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_en  (sample_en),
        .counter_in (counter_in),
        .clear      (clear),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .evt_ts     (evt_ts),
        .level      (level),
        .drop_count (drop_count),
        .overflow   (overflow)
`ifdef CCC_DELTA_EN
        ,
        .evt_delta  (evt_delta)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] ts;
        logic [31:0] delta;
    } ev_t;

    // Reference model: a queue of events plus the observable bookkeeping
    ev_t         mq[$];
    logic [31:0] m_ts;
    logic [31:0] m_prev;
    logic        m_primed;
    int          m_drops;
    logic        m_ovf;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ts     = 0;
        m_prev   = 0;
        m_primed = 1'b0;
        m_drops  = 0;
        m_ovf    = 1'b0;
    endtask

    // One clock of the specification's rules applied to the event queue
    task automatic model_step(input logic se, input logic [31:0] cin,
                              input logic clr, input logic rdy);
        bit   popped;
        ev_t  e;
        if (clr) begin
            mq.delete();
            m_drops  = 0;
            m_ovf    = 1'b0;
            m_primed = 1'b0;
        end else begin
            popped = (mq.size() > 0) && rdy;
            if (se && (!m_primed || cin != m_prev)) begin
                if (mq.size() == DEPTH && !popped) begin
                    if (m_drops < 65535) m_drops++;
                    m_ovf = 1'b1;
                end else begin
                    e.data  = cin;
                    e.ts    = m_ts;
                    e.delta = m_primed ? cin - m_prev : 32'd0;
                    mq.push_back(e);
                end
            end
            if (popped) void'(mq.pop_front());
            if (se) begin
                m_prev   = cin;
                m_primed = 1'b1;
            end
        end
        m_ts = m_ts + 32'd1;
    endtask

    task automatic compare_model();
        ev_t h;
        h = '{default: 32'd0};
        if (mq.size() > 0) h = mq[0];
        chk("evt_valid",  64'(evt_valid),  64'(mq.size() > 0));
        chk("evt_data",   64'(evt_data),   64'(h.data));
        chk("evt_ts",     64'(evt_ts),     64'(h.ts));
        chk("level",      64'(level),      64'(mq.size()));
        chk("drop_count", 64'(drop_count), 64'(m_drops));
        chk("overflow",   64'(overflow),   64'(m_ovf));
`ifdef CCC_DELTA_EN
        chk("evt_delta",  64'(evt_delta),  64'(h.delta));
`endif
    endtask

    // Drive one cycle's inputs, clock, update model, sample #1 after the edge
    task automatic cycle(input logic se, input logic [31:0] cin,
                         input logic clr, input logic rdy);
        sample_en  = se;
        counter_in = cin;
        clear      = clr;
        evt_ready  = rdy;
        @(posedge clk);
        model_step(se, cin, clr, rdy);
        #1;
        compare_model();
    endtask

    typedef struct {
        logic        se;
        logic [31:0] cin;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic [31:0] ets;
        int          lvl;
    } vec_t;

    vec_t        t1[10];
    logic [31:0] t0;

    initial begin
        rst_n      = 1'b0;
        sample_en  = 1'b0;
        counter_in = '0;
        clear      = 1'b0;
        evt_ready  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(evt_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_drop",  64'(drop_count), 64'd0);
        chk("rst_ovf",   64'(overflow), 64'd0);
        chk("rst_data",  64'(evt_data), 64'd0);
        chk("rst_ts",    64'(evt_ts), 64'd0);
        rst_n = 1'b1;

        // Held counter value yields exactly one event stamped with ts=0
        for (int i = 0; i < 10; i++) begin
            t1[i] = '{se: 1'b1, cin: 32'd5, rdy: 1'b1, ev: 1'b0, ed: 32'd0, ets: 32'd0, lvl: 0};
        end
        t1[0].ev  = 1'b1;
        t1[0].ed  = 32'd5;
        t1[0].lvl = 1;
        for (int i = 0; i < 10; i++) begin
            cycle(t1[i].se, t1[i].cin, 1'b0, t1[i].rdy);
            chk("t1_valid", 64'(evt_valid), 64'(t1[i].ev));
            chk("t1_data",  64'(evt_data),  64'(t1[i].ed));
            chk("t1_ts",    64'(evt_ts),    64'(t1[i].ets));
            chk("t1_level", 64'(level),     64'(t1[i].lvl));
        end

        // Twelve distinct samples into an 8-deep FIFO with consumer stalled
        t0 = m_ts;
        for (int i = 0; i < 12; i++) cycle(1'b1, 32'd100 + 32'(i), 1'b0, 1'b0);
        chk("t2_level", 64'(level), 64'd8);
        chk("t2_drop",  64'(drop_count), 64'd4);
        chk("t2_ovf",   64'(overflow), 64'd1);
        for (int i = 0; i < 8; i++) begin
            chk("t2_drain_data", 64'(evt_data), 64'(32'd100 + 32'(i)));
            chk("t2_drain_ts",   64'(evt_ts),   64'(t0 + 32'(i)));
            cycle(1'b0, 32'd0, 1'b0, 1'b1);
        end
        chk("t2_empty", 64'(level), 64'd0);

        // Full FIFO: simultaneous push and pop is not a drop
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'd200 + 32'(i), 1'b0, 1'b0);
        chk("t3_full", 64'(level), 64'd8);
        cycle(1'b1, 32'd208, 1'b0, 1'b1);
        chk("t3_level", 64'(level), 64'd8);
        chk("t3_drop",  64'(drop_count), 64'd4);
        chk("t3_head",  64'(evt_data), 64'd201);

        // Clear at level 5 with prev==9; following sample of 9 must still push
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 32'd9, 1'b0, 1'b0);
        chk("t4_pre_level", 64'(level), 64'd5);
        cycle(1'b1, 32'd9, 1'b1, 1'b0);
        chk("t4_level", 64'(level), 64'd0);
        chk("t4_drop",  64'(drop_count), 64'd0);
        chk("t4_ovf",   64'(overflow), 64'd0);
        cycle(1'b1, 32'd9, 1'b0, 1'b0);
        chk("t4_push_level", 64'(level), 64'd1);
        chk("t4_push_data",  64'(evt_data), 64'd9);

        // Asynchronous reset between edges while an event is pending
        cycle(1'b0, 32'd0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_valid", 64'(evt_valid), 64'd0);
        chk("t5_level", 64'(level), 64'd0);
        model_reset();
        #1 rst_n = 1'b1;
        cycle(1'b1, 32'd77, 1'b0, 1'b0);
        chk("t5_ts_restart", 64'(evt_ts), 64'd0);
        chk("t5_data",       64'(evt_data), 64'd77);

        // Wrapping delta from 0xFFFFFFFF to 1 (data order checked in either build)
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        cycle(1'b1, 32'd1, 1'b0, 1'b0);
        chk("t6_first_data", 64'(evt_data), 64'hFFFF_FFFF);
`ifdef CCC_DELTA_EN
        chk("t6_first_delta", 64'(evt_delta), 64'd0);
`endif
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        chk("t6_second_data", 64'(evt_data), 64'd1);
`ifdef CCC_DELTA_EN
        chk("t6_second_delta", 64'(evt_delta), 64'd2);
`endif

        // drop_count saturation at 0xFFFF
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 65545; i++) cycle(1'b1, 32'd1000 + 32'(i), 1'b0, 1'b0);
        chk("sat_drop", 64'(drop_count), 64'hFFFF);
        chk("sat_ovf",  64'(overflow), 64'd1);
        chk("sat_level", 64'(level), 64'd8);

        // Random traffic with a small value range to get repeated samples
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)), 32'($urandom_range(0, 3)),
                  1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
